// File: rtl/pid_pkg.sv
// Shared types and default constants for the PID update sequencer.
package pid_pkg;

  localparam int PID_DW   = 16;
  localparam int PID_FRAC = 8;
  localparam int PID_ACCW = 34;

  localparam logic signed [PID_DW-1:0] PID_S_MAX = 16'sh7FFF;
  localparam logic signed [PID_DW-1:0] PID_S_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERR   = 3'd1,
    MUL_P = 3'd2,
    MUL_I = 3'd3,
    MUL_D = 3'd4,
    SUM   = 3'd5
  } state_t;

endpackage

// File: rtl/pid_sat.sv
// Signed narrowing saturator: clamps a wide two's-complement value into OUT_W bits.
module pid_sat #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    if (din > MAXV)
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    else if (din < MINV)
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = din[OUT_W-1:0];
  end

endmodule

// File: rtl/pid_sequencer.sv
// One PID update per accepted sample over a single shared signed multiplier.
// Derivative term and MUL_D state are present only when PID_DERIV_EN is defined.
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int DW   = PID_DW,
  parameter int FRAC = PID_FRAC,
  parameter int ACCW = PID_ACCW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] setpoint,
  input  logic signed [DW-1:0] measurement,
  input  logic signed [DW-1:0] kp,
  input  logic signed [DW-1:0] ki,
  input  logic signed [DW-1:0] kd,
  input  logic                 clear_int,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [DW-1:0] pid_out
);

  state_t state;

  logic signed [DW-1:0]   sp_q, meas_q, kp_q, ki_q;
  logic signed [DW-1:0]   e_reg, int_reg;
  logic signed [ACCW-1:0] acc;

  logic signed [DW:0]     e_wide, int_wide;
  logic signed [DW-1:0]   e_sat, int_new, out_sat;
  logic signed [DW-1:0]   op_a, op_b;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] term;

  assign e_wide   = {sp_q[DW-1], sp_q} - {meas_q[DW-1], meas_q};
  assign int_wide = {int_reg[DW-1], int_reg} + {e_reg[DW-1], e_reg};

  pid_sat #(.IN_W(DW+1), .OUT_W(DW)) u_sat_err (.din(e_wide),   .dout(e_sat));
  pid_sat #(.IN_W(DW+1), .OUT_W(DW)) u_sat_int (.din(int_wide), .dout(int_new));
  pid_sat #(.IN_W(ACCW), .OUT_W(DW)) u_sat_out (.din(acc),      .dout(out_sat));

`ifdef PID_DERIV_EN
  logic signed [DW-1:0] kd_q, eprev_reg, d_sat;
  logic signed [DW:0]   d_wide;

  assign d_wide = {e_reg[DW-1], e_reg} - {eprev_reg[DW-1], eprev_reg};
  pid_sat #(.IN_W(DW+1), .OUT_W(DW)) u_sat_der (.din(d_wide), .dout(d_sat));
`else
  logic unused_kd;
  assign unused_kd = ^kd;
`endif

  // Operand mux for the single multiplier; the integral term uses the freshly clamped sum.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      MUL_P: begin op_a = kp_q; op_b = e_reg;   end
      MUL_I: begin op_a = ki_q; op_b = int_new; end
`ifdef PID_DERIV_EN
      MUL_D: begin op_a = kd_q; op_b = d_sat;   end
`endif
      default: ;
    endcase
  end

  assign prod = op_a * op_b;
  assign term = ACCW'(prod >>> FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      pid_out   <= '0;
      sp_q      <= '0;
      meas_q    <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      e_reg     <= '0;
      int_reg   <= '0;
      acc       <= '0;
`ifdef PID_DERIV_EN
      kd_q      <= '0;
      eprev_reg <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_int) begin
            int_reg   <= '0;
`ifdef PID_DERIV_EN
            eprev_reg <= '0;
`endif
          end
          if (sample_valid) begin
            sp_q   <= setpoint;
            meas_q <= measurement;
            kp_q   <= kp;
            ki_q   <= ki;
`ifdef PID_DERIV_EN
            kd_q   <= kd;
`endif
            busy   <= 1'b1;
            state  <= ERR;
          end
        end
        ERR: begin
          e_reg <= e_sat;
          acc   <= '0;
          state <= MUL_P;
        end
        MUL_P: begin
          acc   <= acc + term;
          state <= MUL_I;
        end
        MUL_I: begin
          int_reg <= int_new;
          acc     <= acc + term;
`ifdef PID_DERIV_EN
          state   <= MUL_D;
`else
          state   <= SUM;
`endif
        end
`ifdef PID_DERIV_EN
        MUL_D: begin
          acc       <= acc + term;
          eprev_reg <= e_reg;
          state     <= SUM;
        end
`endif
        SUM: begin
          pid_out   <= out_sat;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pid_sequencer.md
Name: pid_sequencer

Overview:
- Sequences one PID control update per sample: error → proportional → integral → derivative → sum.
- Time-shares a single signed 16x16 multiplier across the three gain terms.
- Owns the error, integral, previous-error, accumulator and output registers, and drives their load enables.
- Sits between the ADC sample interface (setpoint/measurement) and the actuator output register.

Parameters:
- DW, 16, data width of setpoint, measurement, gains, output (signed)
- FRAC, 8, fractional bits of gains (Q8.8); products arithmetic-shifted right by FRAC
- ACCW, 34, accumulator width (holds three shifted products without overflow)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  new setpoint/measurement pair offered
- setpoint  in  DW  signed target
- measurement  in  DW  signed plant value
- kp  in  DW  signed proportional gain, Q8.8
- ki  in  DW  signed integral gain, Q8.8
- kd  in  DW  signed derivative gain, Q8.8
- clear_int  in  1  synchronous clear of integral and previous-error state
- busy  out  1  high while an update is in progress
- out_valid  out  1  one-cycle pulse, new pid_out
- pid_out  out  DW  signed saturated controller output

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, out_valid=0, pid_out=0; e_reg, int_reg, eprev_reg, acc all cleared. Reset mid-update aborts the update; no out_valid is produced.
- Gain sampling: setpoint, measurement, kp, ki, kd are captured on the accepting edge and held for the whole update.
- Accept: in IDLE, sample_valid=1 at a rising edge → capture, go to ERR, busy=1.
- sample_valid while busy is ignored; there is no queueing.
- FSM (one state per cycle):
  - IDLE → ERR → MUL_P → MUL_I → MUL_D → SUM → IDLE.
- ERR:
  - e = setpoint − measurement, computed at 17 bits and saturated to DW → e_reg.
  - acc=0.
- MUL_P: acc += (kp*e_reg) >>> FRAC.
- MUL_I:
  - int_new = sat_DW(int_reg + e_reg); int_reg <= int_new (anti-windup clamp).
  - acc += (ki*int_new) >>> FRAC.
- MUL_D:
  - d = sat_DW(e_reg − eprev_reg); acc += (kd*d) >>> FRAC.
  - eprev_reg <= e_reg.
- SUM:
  - pid_out <= sat_DW(acc); out_valid=1 on the following cycle.
  - busy drops in the cycle after SUM (back in IDLE).
- Latency: out_valid is high in the 6th cycle after the accepting edge. pid_out holds until the next result.
- Back-to-back: the earliest next accept is the IDLE cycle where out_valid=1, giving 6 cycles per sample.
- Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1], i.e. 16'h8000 / 16'h7FFF.
- clear_int:
  - In IDLE: clears int_reg and eprev_reg on that edge.
  - Coincident with sample_valid in IDLE: the clear applies first, so the new update sees int_reg=0 and eprev_reg=0.
  - While busy: ignored.

Optional Feature:
- Macro: PID_DERIV_EN.
- Defined: MUL_D state present, derivative term included, 6-cycle latency.
- Undefined:
  - MUL_D state, kd usage and eprev_reg are removed; kd port remains but is unused.
  - FSM goes MUL_I → SUM; out_valid at the 5th cycle after accept; 5-cycle throughput.

Decomposition:
- Package pid_pkg:
  - state enum (IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM)
  - DW / FRAC / ACCW default constants
  - signed min/max constants
- Sub-module pid_sat: parameterised signed narrowing saturator (IN_W → OUT_W). Instanced for error, integral, derivative and output clamps.
- Shared multiplier is a single inline signed multiply with an FSM-driven operand mux; it is not a separate module.

Test Plan:
- Proportional: kp=0x0100, ki=kd=0, sp=100, meas=40 → out_valid 6 cycles after accept, pid_out=60, busy high for cycles 1–5.
- Integral: kp=kd=0, ki=0x0080, three samples with e=10 → pid_out=5, 10, 15. Then pulse clear_int, next sample e=10 → 5.
- Derivative (PID_DERIV_EN): kd=0x0100, kp=ki=0, samples e=10 then e=25 → pid_out=10 then 15. Without the macro, pid_out=0 and latency=5.
- Saturation: sp=32767, meas=−32768, kp=0x0200 → e clamps to 32767, pid_out=0x7FFF. Negated inputs → pid_out=0x8000.
- Busy drop: sample_valid held high continuously → exactly one update per 6 cycles. Inputs changed mid-update do not affect the result.
- Reset mid-op: assert rst_n=0 during MUL_I → all outputs 0 immediately. No out_valid afterwards; the next sample behaves as if from a clean state.
